// File: rtl/board_buttons_pkg.sv
// Shared state encodings, default timing constants and a small helper for the board button logic.
package board_buttons_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        WAIT2  = 3'd2,
        PRESS2 = 3'd3,
        HOLD   = 3'd4
    } btn_state_e;

    localparam int BTN_CNT_W         = 25;
    localparam int BTN_LONG_CYCLES   = 25_000_000;
    localparam int BTN_DCLICK_CYCLES = 15_000_000;
    localparam int BTN_REPEAT_CYCLES = 5_000_000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/board_edge_detect.sv
// Registers the debounced level and flags its rising/falling edges against the previous sample.
module board_edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic r_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_q <= 1'b0;
        else          r_q <= d;
    end

    assign q    = r_q;
    assign rise = d & ~r_q;
    assign fall = ~d & r_q;

endmodule

// File: rtl/board_button_events.sv
// Classifies debounced presses into click / double-click / long-press pulses.
// Define BTN_AUTOREPEAT_EN to add periodic repeat_tick pulses while a long press is held.
module board_button_events
    import board_buttons_pkg::*;
#(
    parameter int CNT_W         = BTN_CNT_W,
    parameter int LONG_CYCLES   = BTN_LONG_CYCLES,
    parameter int DCLICK_CYCLES = BTN_DCLICK_CYCLES,
    parameter int REPEAT_CYCLES = BTN_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic db_level,
    output logic pressed,
    output logic click_tick,
    output logic dclick_tick,
    output logic long_tick,
    output logic repeat_tick
);

    localparam logic [CNT_W-1:0] LONG_M1   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] DCLICK_M1 = CNT_W'(DCLICK_CYCLES - 1);
    // Every state leaves or reloads at its terminal value, so capping at the largest one is a true saturation.
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(max3(LONG_CYCLES, DCLICK_CYCLES, REPEAT_CYCLES) - 1);
`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_M1 = CNT_W'(REPEAT_CYCLES - 1);
    logic w_repeat;
    logic r_repeat;
`endif

    btn_state_e       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic             w_rise, w_fall, w_level_q;
    logic             w_click, w_dclick, w_long;
    logic             r_click, r_dclick, r_long;

    board_edge_detect u_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (db_level),
        .q       (w_level_q),
        .rise    (w_rise),
        .fall    (w_fall)
    );

    assign w_cnt_inc = (r_cnt >= CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Edges are tested before terminal counts so a same-cycle edge always wins.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_cnt_inc;
        w_click     = 1'b0;
        w_dclick    = 1'b0;
        w_long      = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        w_repeat    = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (w_rise) w_state_nxt = PRESS1;
            end
            PRESS1: begin
                if (w_fall) begin
                    w_state_nxt = WAIT2;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == LONG_M1) begin
                    w_long      = 1'b1;
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT2: begin
                if (w_rise) begin
                    w_state_nxt = PRESS2;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DCLICK_M1) begin
                    w_click     = 1'b1;
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            PRESS2: begin
                if (w_fall) begin
                    w_dclick    = 1'b1;
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == LONG_M1) begin
                    w_click     = 1'b1;
                    w_long      = 1'b1;
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = '0;
                end
            end
            HOLD: begin
`ifdef BTN_AUTOREPEAT_EN
                if (w_fall) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == REPEAT_M1) begin
                    w_repeat  = 1'b1;
                    w_cnt_nxt = '0;
                end
`else
                w_cnt_nxt = '0;
                if (w_fall) w_state_nxt = IDLE;
`endif
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        if (!en) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_click     = 1'b0;
            w_dclick    = 1'b0;
            w_long      = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            w_repeat    = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_click  <= 1'b0;
            r_dclick <= 1'b0;
            r_long   <= 1'b0;
        end else begin
            r_click  <= w_click;
            r_dclick <= w_dclick;
            r_long   <= w_long;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_repeat <= 1'b0;
        else          r_repeat <= w_repeat;
    end
    assign repeat_tick = r_repeat;
`else
    assign repeat_tick = 1'b0;
`endif

    assign pressed     = w_level_q;
    assign click_tick  = r_click;
    assign dclick_tick = r_dclick;
    assign long_tick   = r_long;

endmodule

// File: tb/tb_board_button_events.sv
// Randomized + directed bench for board_button_events against a timestamp-based reference model.
module tb_board_button_events;

    localparam int CNT_W  = 8;
    localparam int LONG   = 20;
    localparam int DCLICK = 10;
    localparam int REPEAT = 5;

    localparam int M_IDLE = 0, M_PRESS = 1, M_GAP = 2, M_PRESS2 = 3, M_HOLD = 4;

    logic clk = 1'b0;
    logic reset_n, en, db_level;
    logic pressed, click_tick, dclick_tick, long_tick, repeat_tick;

    board_button_events #(
        .CNT_W         (CNT_W),
        .LONG_CYCLES   (LONG),
        .DCLICK_CYCLES (DCLICK),
        .REPEAT_CYCLES (REPEAT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .db_level    (db_level),
        .pressed     (pressed),
        .click_tick  (click_tick),
        .dclick_tick (dclick_tick),
        .long_tick   (long_tick),
        .repeat_tick (repeat_tick)
    );

    always #10 clk = ~clk;

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: events are timed from the cycle a phase began, not from a counter.
    int cyc_n = 0;
    int m_mode = M_IDLE;
    int m_t0 = 0;
    bit m_prev = 1'b0;
    bit e_click, e_dclick, e_long, e_repeat, e_pressed;

    task automatic model_reset();
        m_mode = M_IDLE;
        m_prev = 1'b0;
        m_t0   = cyc_n;
    endtask

    task automatic model_step(input bit lvl, input bit e);
        bit rise, fall;
        int age;
        rise = lvl && !m_prev;
        fall = !lvl && m_prev;
        m_prev = lvl;
        e_pressed = lvl;
        {e_click, e_dclick, e_long, e_repeat} = 4'b0;
        age = cyc_n - m_t0;
        if (!e) m_mode = M_IDLE;
        else begin
            case (m_mode)
                M_IDLE:  if (rise) begin m_mode = M_PRESS; m_t0 = cyc_n; end
                M_PRESS: if (fall) begin m_mode = M_GAP; m_t0 = cyc_n; end
                         else if (age == LONG) begin e_long = 1; m_mode = M_HOLD; m_t0 = cyc_n; end
                M_GAP:   if (rise) begin m_mode = M_PRESS2; m_t0 = cyc_n; end
                         else if (age == DCLICK) begin e_click = 1; m_mode = M_IDLE; end
                M_PRESS2: if (fall) begin e_dclick = 1; m_mode = M_IDLE; end
                          else if (age == LONG) begin e_click = 1; e_long = 1; m_mode = M_HOLD; m_t0 = cyc_n; end
                default: begin
                    if (fall) m_mode = M_IDLE;
`ifdef BTN_AUTOREPEAT_EN
                    else if (age == REPEAT) begin e_repeat = 1; m_t0 = cyc_n; end
`endif
                end
            endcase
        end
    endtask

    int o_click, o_dclick, o_long, o_repeat;
    int t_click, t_long, t_repeat_first;

    task automatic clr_obs();
        {o_click, o_dclick, o_long, o_repeat} = '0;
        t_click = -1; t_long = -1; t_repeat_first = -1;
    endtask

    task automatic cyc(input bit lvl, input bit e);
        @(negedge clk);
        db_level = lvl;
        en = e;
        @(posedge clk);
        cyc_n++;
        model_step(lvl, e);
        #1;
        chk("pressed", 32'(pressed), 32'(e_pressed));
        chk("click_tick", 32'(click_tick), 32'(e_click));
        chk("dclick_tick", 32'(dclick_tick), 32'(e_dclick));
        chk("long_tick", 32'(long_tick), 32'(e_long));
        chk("repeat_tick", 32'(repeat_tick), 32'(e_repeat));
        if (click_tick)  begin o_click++;  t_click = cyc_n; end
        if (dclick_tick) o_dclick++;
        if (long_tick)   begin o_long++;   t_long = cyc_n; end
        if (repeat_tick) begin o_repeat++; if (t_repeat_first < 0) t_repeat_first = cyc_n; end
    endtask

    task automatic hold(input bit lvl, input int n);
        for (int i = 0; i < n; i++) cyc(lvl, 1'b1);
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_pressed"}, 32'(pressed), 0);
        chk({tag, "_ticks"}, 32'({click_tick, dclick_tick, long_tick, repeat_tick}), 0);
    endtask

    int mark;

    initial begin
        reset_n = 1'b0; en = 1'b1; db_level = 1'b0;
        #5 chk_outs_zero("reset");
        @(negedge clk); reset_n = 1'b1; model_reset();
        hold(0, 3);

        // single click: tick DCLICK cycles after the fall
        clr_obs(); hold(1, 5); mark = cyc_n + 1; hold(0, 15);
        chk("t1_clicks", o_click, 1);
        chk("t1_latency", t_click - mark, DCLICK);
        chk("t1_others", o_dclick + o_long, 0);

        // double click
        clr_obs(); hold(1, 5); hold(0, 4); hold(1, 5); hold(0, 15);
        chk("t2_dclicks", o_dclick, 1);
        chk("t2_clicks", o_click, 0);

        // long press, silent release
        clr_obs(); mark = cyc_n + 1; hold(1, 30);
        chk("t3_long_lat", t_long - mark, LONG);
        hold(0, 15);
        chk("t3_longs", o_long, 1);
        chk("t3_clicks", o_click + o_dclick, 0);

        // second press held long: click and long together
        clr_obs(); hold(1, 3); hold(0, 3); hold(1, 25); hold(0, 15);
        chk("t4_counts", 32'({o_click[7:0], o_long[7:0]}), 32'h0101);
        chk("t4_same_cycle", t_click, t_long);

        // enable dropped mid-press
        clr_obs(); hold(1, 8); cyc(1, 1'b0); hold(1, 4); hold(0, 15);
        chk("t5_no_ticks", o_click + o_dclick + o_long + o_repeat, 0);
        clr_obs(); hold(1, 5); hold(0, 15);
        chk("t5_idle_after", o_click, 1);

        // long hold with auto-repeat
        clr_obs(); mark = cyc_n + 1; hold(1, 41); hold(0, 10);
        chk("t6_long_lat", t_long - mark, LONG);
`ifdef BTN_AUTOREPEAT_EN
        chk("t6_repeats", o_repeat, 4);
        chk("t6_first_rep", t_repeat_first - mark, LONG + REPEAT);
`else
        chk("t6_repeats", o_repeat, 0);
`endif

        // async reset while waiting for a second press
        clr_obs(); hold(1, 5); hold(0, 4);
        @(negedge clk); #3 reset_n = 1'b0;
        #1 chk_outs_zero("t7_async");
        @(negedge clk); reset_n = 1'b1; model_reset();
        hold(0, 20);
        chk("t7_no_click", o_click, 0);

        // randomized runs of levels with occasional enable drops
        for (int s = 0; s < 250; s++) begin
            int len;
            bit lvl;
            lvl = s[0];
            len = (s % 7 == 0) ? $urandom_range(18, 30) : $urandom_range(1, 12);
            for (int i = 0; i < len; i++) cyc(lvl, ($urandom_range(0, 39) != 0));
        end
        hold(0, 25);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
